// File: rtl/fp_pkg.sv
// Shared encodings, special-case record and bit-pattern helpers for the
// iterative floating-point multiplier.
package fp_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RDN = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RTZ = 2'b11;

    localparam int FLG_INX = 0;
    localparam int FLG_UNF = 1;
    localparam int FLG_OVF = 2;
    localparam int FLG_INV = 3;

    typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} fmul_state_e;

    typedef struct packed {
        logic nan;
        logic inv;
        logic inf;
        logic zero;
    } fp_special_t;

    // Patterns are built in a 64-bit container; callers truncate to their width.
    function automatic logic [63:0] fp_inf(input int ew, input int fw, input logic sgn);
        logic [63:0] v;
        v = ((64'd1 << ew) - 64'd1) << fw;
        v[ew+fw] = sgn;
        return v;
    endfunction

    function automatic logic [63:0] fp_max_finite(input int ew, input int fw, input logic sgn);
        logic [63:0] v;
        v = (((64'd1 << ew) - 64'd2) << fw) | ((64'd1 << fw) - 64'd1);
        v[ew+fw] = sgn;
        return v;
    endfunction

    function automatic logic [63:0] fp_qnan(input int ew, input int fw, input logic sgn,
                                            input logic [63:0] src);
        return fp_inf(ew, fw, sgn) | (64'd1 << (fw - 1)) |
               (src & ((64'd1 << (fw - 1)) - 64'd1));
    endfunction

endpackage

// File: rtl/fmul_iter_if.sv
// Operand/result valid-ready channels of the iterative multiplier.
interface fmul_iter_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    localparam int DW = EXP_W + FRAC_W + 1;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [1:0]    rm;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] s;
    logic [3:0]    flags;

    modport master (output in_valid, a, b, rm, out_ready,
                    input  in_ready, out_valid, s, flags);
    modport slave  (input  in_valid, a, b, rm, out_ready,
                    output in_ready, out_valid, s, flags);
endinterface

// File: rtl/fmul_frac_iter.sv
// Shift-and-add significand multiplier: RADIX_BITS multiplier bits per cycle,
// LSB first, into a double-width accumulator.
module fmul_frac_iter #(
    parameter int SW         = 24,
    parameter int RADIX_BITS = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [SW-1:0] a_sig,
    input  logic [SW-1:0] b_sig,
    output logic          done,
    output logic [2*SW-1:0] prod
);
    localparam int N  = (SW + RADIX_BITS - 1) / RADIX_BITS;
    localparam int PW = 2 * SW;
    localparam int AW = N * RADIX_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic          busy;
    logic [CW-1:0] cnt;
    logic [AW-1:0] a_sh;
    logic [PW-1:0] b_sh;
    logic [PW-1:0] acc;
    logic [PW-1:0] pp;

    // b_sh already carries the digit weight, so the partial product needs no barrel shift
    always_comb begin
        pp = '0;
        for (int j = 0; j < RADIX_BITS; j++)
            if (a_sh[j]) pp = pp + (b_sh << j);
    end

    assign done = busy && (cnt == CW'(N - 1));
    assign prod = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            a_sh <= AW'(a_sig);
            b_sh <= PW'(b_sig);
            acc  <= '0;
        end else if (busy) begin
            acc  <= acc + pp;
            a_sh <= a_sh >> RADIX_BITS;
            b_sh <= b_sh << RADIX_BITS;
            cnt  <= cnt + CW'(1);
            if (done) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/fmul_iter.sv
// Multi-cycle IEEE-754 multiplier: iterative significand product, then one
// normalise cycle and one round cycle, with full exception flags.
module fmul_iter import fp_pkg::*; #(
    parameter int EXP_W      = 8,
    parameter int FRAC_W     = 23,
    parameter int RADIX_BITS = 2
) (
    input logic        clk,
    input logic        rst,
    fmul_iter_if.slave bus
);
    localparam int DW   = EXP_W + FRAC_W + 1;
    localparam int SW   = FRAC_W + 1;
    localparam int PW   = 2 * SW;
    localparam int EW   = EXP_W + 2;
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int EMAX = 2 ** EXP_W - 1;

    fmul_state_e state_q, state_d;
    logic        start, in_rdy, out_vld, mul_done;
    logic [PW-1:0] prod;

    logic [EXP_W-1:0]  ea_q, eb_q;
    logic [1:0]        rm_q;
    logic              sign_q;
    fp_special_t       sp_q, sp_d;
    logic [FRAC_W-1:0] nan_frac_q;

    logic [PW-1:0]        norm_m_q;
    logic signed [EW-1:0] norm_e_q;
    logic                 norm_st_q;
    logic [DW-1:0]        s_q, res_s;
    logic [3:0]           flags_q, res_f;

    // Operand decode at accept time
    logic [EXP_W-1:0]  ea_i, eb_i;
    logic [FRAC_W-1:0] fa_i, fb_i;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign ea_i   = bus.a[DW-2 -: EXP_W];
    assign eb_i   = bus.b[DW-2 -: EXP_W];
    assign fa_i   = bus.a[FRAC_W-1:0];
    assign fb_i   = bus.b[FRAC_W-1:0];
    assign a_nan  = (&ea_i) && (|fa_i);
    assign b_nan  = (&eb_i) && (|fb_i);
    assign a_inf  = (&ea_i) && !(|fa_i);
    assign b_inf  = (&eb_i) && !(|fb_i);
    assign a_zero = !(|ea_i) && !(|fa_i);
    assign b_zero = !(|eb_i) && !(|fb_i);

    always_comb begin
        sp_d.nan  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
        sp_d.inv  = (a_inf & b_zero) | (a_zero & b_inf) |
                    (a_nan & ~fa_i[FRAC_W-1]) | (b_nan & ~fb_i[FRAC_W-1]);
        sp_d.inf  = a_inf | b_inf;
        sp_d.zero = a_zero | b_zero;
    end

    fmul_frac_iter #(.SW(SW), .RADIX_BITS(RADIX_BITS)) u_frac (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_sig ({|ea_i, fa_i}),
        .b_sig ({|eb_i, fb_i}),
        .done  (mul_done),
        .prod  (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    start   = 1'b1;
                    state_d = MUL;
                end
            end
            MUL:   if (mul_done) state_d = NORM;
            NORM:  state_d = ROUND;
            ROUND: state_d = DONE;
            DONE: begin
                out_vld = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Normalise: hidden bit lands at PW-2; exponent 0 means denormal with
    // effective exponent 1.
    int            ei_n, lz, sh, rs;
    logic [PW-1:0] m_n;
    logic          st_n;

    always_comb begin
        ei_n = int'(ea_q) + int'(eb_q) - BIAS + int'(ea_q == '0) + int'(eb_q == '0);
        m_n  = prod;
        st_n = 1'b0;
        lz   = PW - 1;
        sh   = 0;
        rs   = 0;
        for (int i = 0; i <= PW - 2; i++)
            if (prod[i]) lz = PW - 2 - i;
        if (prod[PW-1]) begin
            m_n  = prod >> 1;
            st_n = prod[0];
            ei_n = ei_n + 1;
        end else if (ei_n > 1) begin
            sh   = (lz < ei_n - 1) ? lz : ei_n - 1;
            m_n  = prod << sh;
            ei_n = ei_n - sh;
        end
        if (ei_n <= 0) begin
            rs = 1 - ei_n;
            if (rs >= PW) begin
                st_n = st_n | (|m_n);
                m_n  = '0;
            end else begin
                st_n = st_n | (|(m_n & ~({PW{1'b1}} << rs)));
                m_n  = m_n >> rs;
            end
            ei_n = 0;
        end
        if (!m_n[PW-2]) ei_n = 0;
    end

    // Round and pack; special cases override the arithmetic result
    logic              hid, lsb, g, r, st, inx, inc, ovf, use_max;
    logic [FRAC_W-1:0] frac;
    logic [SW:0]       sum;
    int                er;

    always_comb begin
        hid  = norm_m_q[PW-2];
        frac = norm_m_q[PW-3 -: FRAC_W];
        lsb  = norm_m_q[SW-1];
        g    = norm_m_q[SW-2];
        r    = norm_m_q[SW-3];
        st   = (|norm_m_q[SW-4:0]) | norm_st_q;
        inx  = g | r | st;
        case (rm_q)
            RM_RNE:  inc = g & (r | st | lsb);
            RM_RDN:  inc = sign_q & inx;
            RM_RUP:  inc = ~sign_q & inx;
            default: inc = 1'b0;
        endcase
        sum = {1'b0, hid, frac} + {{SW{1'b0}}, inc};
        er  = int'(norm_e_q) + int'(sum[SW]) + int'((norm_e_q == '0) && sum[FRAC_W]);
        ovf = er >= EMAX;
        use_max = (rm_q == RM_RTZ) || (rm_q == RM_RDN && !sign_q) ||
                  (rm_q == RM_RUP && sign_q);

        res_s          = {sign_q, er[EXP_W-1:0], sum[FRAC_W-1:0]};
        res_f          = '0;
        res_f[FLG_INX] = inx;
        res_f[FLG_UNF] = (norm_e_q == '0) && inx;
        if (ovf) begin
            res_s = use_max ? DW'(fp_max_finite(EXP_W, FRAC_W, sign_q))
                            : DW'(fp_inf(EXP_W, FRAC_W, sign_q));
            res_f = '0;
            res_f[FLG_OVF] = 1'b1;
            res_f[FLG_INX] = 1'b1;
        end
        if (sp_q.nan) begin
            res_s = DW'(fp_qnan(EXP_W, FRAC_W, sign_q, 64'(nan_frac_q)));
            res_f = '0;
            res_f[FLG_INV] = sp_q.inv;
        end else if (sp_q.inf) begin
            res_s = DW'(fp_inf(EXP_W, FRAC_W, sign_q));
            res_f = '0;
        end else if (sp_q.zero) begin
            res_s = {sign_q, {(DW-1){1'b0}}};
            res_f = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ea_q       <= '0;
            eb_q       <= '0;
            rm_q       <= RM_RNE;
            sign_q     <= 1'b0;
            sp_q       <= '0;
            nan_frac_q <= '0;
            norm_m_q   <= '0;
            norm_e_q   <= '0;
            norm_st_q  <= 1'b0;
            s_q        <= '0;
            flags_q    <= '0;
        end else begin
            if (start) begin
                ea_q       <= ea_i;
                eb_q       <= eb_i;
                rm_q       <= bus.rm;
                sign_q     <= bus.a[DW-1] ^ bus.b[DW-1];
                sp_q       <= sp_d;
                nan_frac_q <= (fa_i > fb_i) ? fa_i : fb_i;
            end
            if (state_q == NORM) begin
                norm_m_q  <= m_n;
                norm_e_q  <= EW'(ei_n);
                norm_st_q <= st_n;
            end
            if (state_q == ROUND) begin
                s_q     <= res_s;
                flags_q <= res_f;
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.s         = s_q;
    assign bus.flags     = flags_q;
endmodule
